alu_op_sequencer: RTL and testbench

// Upstream stimulus/check stage for the 4-bit ALU under test (clean or trojan variant).
// It issues pseudo-random operand/op triples from a 16-bit LFSR, one per 3-cycle ALU frame (IDLE/EXEC/WB).
// It holds the operands stable for the whole frame and checks the ALU's registered outputs against an internal golden model.
// It folds every observed result into a MISR signature, which the trace/side-channel harness compares across variants.

---
 rtl/alu_op_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - LFSR-driven op issuer, golden-model checker and MISR for the 4-bit ALU
module alu_op_sequencer #(
    parameter int          NUM_OPS   = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic [15:0] op_count,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] first_err_idx,
    output logic [15:0] signature
);

    localparam logic [15:0] NUM_OPS_W = 16'(NUM_OPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  phase;
    logic [15:0] lfsr;
    logic [15:0] issue_cnt;
    // op_live: the operand registers hold a real op that the ALU samples at the next WB edge
    logic        op_live;
    logic        pend;
    logic [6:0]  expected;

    logic        accept;
    logic        issue;
    logic        wb_edge;
    logic        check;
    logic [4:0]  gold_sum;
    logic [4:0]  gold_dif;
    logic [3:0]  gold_res;
    logic        gold_c;
    logic        gold_v;
    logic [6:0]  golden;
    logic [6:0]  observed;
    logic        miscompare;
    logic [15:0] lfsr_step;
    logic [15:0] sig_step;

    assign busy     = (state == S_ARM) || (state == S_RUN) || (state == S_DRAIN);
    assign accept   = (state == S_IDLE) && start;
    assign wb_edge  = (phase == 2'd2);
    assign check    = (phase == 2'd0) && pend;
    assign observed = {alu_overflow, alu_zero, alu_carry, alu_result};
    assign miscompare = (observed != expected);
    assign lfsr_step  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign sig_step   = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
                        ^ {9'd0, observed};

    // Next-state and issue decision; issues are aligned to the ALU's WB phase
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (wb_edge) begin
                    issue      = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (wb_edge) begin
                    if (issue_cnt == NUM_OPS_W) begin
                        state_next = S_DRAIN;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (phase == 2'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Golden model of the op the ALU is sampling on this WB edge, in 5-bit arithmetic
    always_comb begin
        gold_sum = {1'b0, alu_a} + {1'b0, alu_b};
        gold_dif = {1'b0, alu_a} - {1'b0, alu_b};
        gold_res = 4'd0;
        gold_c   = 1'b0;
        gold_v   = 1'b0;
        case (alu_op)
            2'b00: begin
                gold_res = gold_sum[3:0];
                gold_c   = gold_sum[4];
                gold_v   = (alu_a[3] == alu_b[3]) && (alu_a[3] != gold_sum[3]);
            end
            2'b01: begin
                gold_res = gold_dif[3:0];
                gold_c   = gold_dif[4];
                gold_v   = (alu_a[3] != alu_b[3]) && (alu_a[3] != gold_dif[3]);
            end
            2'b10: begin
                gold_res = alu_a & alu_b;
            end
            default: begin
                gold_res = alu_a | alu_b;
            end
        endcase
        golden = {gold_v, (gold_res == 4'd0), gold_c, gold_res};
    end

    // Frame phase, issue pipeline, checker counters and signature
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            phase         <= 2'd0;
            lfsr          <= LFSR_SEED;
            issue_cnt     <= 16'd0;
            op_live       <= 1'b0;
            pend          <= 1'b0;
            expected      <= 7'd0;
            done          <= 1'b0;
            alu_a         <= 4'd0;
            alu_b         <= 4'd0;
            alu_op        <= 2'd0;
            op_count      <= 16'd0;
            mismatch_cnt  <= 16'd0;
            first_err_idx <= 16'hFFFF;
            signature     <= 16'd0;
        end else begin
            state <= state_next;
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            if (accept) begin
                lfsr          <= LFSR_SEED;
                issue_cnt     <= 16'd0;
                op_live       <= 1'b0;
                pend          <= 1'b0;
                done          <= 1'b0;
                op_count      <= 16'd0;
                mismatch_cnt  <= 16'd0;
                first_err_idx <= 16'hFFFF;
                signature     <= 16'd0;
            end else begin
                if (issue) begin
                    alu_a     <= lfsr[3:0];
                    alu_b     <= lfsr[7:4];
                    alu_op    <= lfsr[9:8];
                    lfsr      <= lfsr_step;
                    issue_cnt <= issue_cnt + 16'd1;
                end
                // The ALU latches the current operands on this edge; its result appears next cycle
                if (wb_edge) begin
                    expected <= golden;
                    pend     <= op_live;
                    op_live  <= issue;
                end
                if (check) begin
                    pend      <= 1'b0;
                    op_count  <= op_count + 16'd1;
                    signature <= sig_step;
                    if (miscompare) begin
                        if (mismatch_cnt != 16'hFFFF) begin
                            mismatch_cnt <= mismatch_cnt + 16'd1;
                        end
                        if (first_err_idx == 16'hFFFF) begin
                            first_err_idx <= op_count;
                        end
                    end
                end
                if ((state == S_DRAIN) && (phase == 2'd0)) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer with behavioural 3-phase ALUs
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start1;
    logic        fault_mode;

    logic        busy, done;
    logic [3:0]  alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [3:0]  alu_result;
    logic        alu_carry, alu_zero, alu_overflow;
    logic [15:0] op_count, mismatch_cnt, first_err_idx, signature;

    logic        busy1, done1;
    logic [3:0]  alu_a1, alu_b1;
    logic [1:0]  alu_op1;
    logic [3:0]  alu_result1;
    logic        alu_carry1, alu_zero1, alu_overflow1;
    logic [15:0] op_count1, mismatch_cnt1, first_err_idx1, signature1;

    logic [1:0]  alu_st;
    logic [1:0]  alu_st1;

    int n_vec;
    int n_err;
    int cyc;

    // Hand-computed: op sequence from seed ACE1 is (1,E,add) (3,C,sub) (7,8,or) (F,0,or)
    // observed words {v,z,c,r}: 0F 17 0F 0F -> clean MISR 0035; op2 bit0 flipped -> 0037
    localparam logic [15:0] SIG_CLEAN  = 16'h0035;
    localparam logic [15:0] SIG_FAULT  = 16'h0037;
    localparam logic [15:0] SIG_CARRY1 = 16'h001F;

    alu_op_sequencer #(.NUM_OPS(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .op_count(op_count), .mismatch_cnt(mismatch_cnt),
        .first_err_idx(first_err_idx), .signature(signature)
    );

    alu_op_sequencer #(.NUM_OPS(1), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_result(alu_result1), .alu_carry(alu_carry1), .alu_zero(alu_zero1),
        .alu_overflow(alu_overflow1), .op_count(op_count1), .mismatch_cnt(mismatch_cnt1),
        .first_err_idx(first_err_idx1), .signature(signature1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [4:0] s;
        logic       c;
        logic       v;
        s = 5'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; c = s[4]; v = (a[3] == b[3]) && (a[3] != s[3]); end
            2'b01: begin s = {1'b0, a} - {1'b0, b}; c = s[4]; v = (a[3] != b[3]) && (a[3] != s[3]); end
            2'b10: s = {1'b0, a & b};
            default: s = {1'b0, a | b};
        endcase
        return {v, (s[3:0] == 4'd0), c, s[3:0]};
    endfunction

    // ALU for dut: samples operands at the end of WB; optional trojan flips result bit0 on op 2
    always @(posedge clk) begin
        logic [6:0] r;
        if (rst) begin
            alu_st <= 2'd0;
            {alu_overflow, alu_zero, alu_carry, alu_result} <= 7'd0;
        end else begin
            alu_st <= (alu_st == 2'd2) ? 2'd0 : alu_st + 2'd1;
            if (alu_st == 2'd2) begin
                r = alu_model(alu_a, alu_b, alu_op);
                if (fault_mode && alu_a == 4'h7 && alu_b == 4'h8 && alu_op == 2'b11) begin
                    r[0] = ~r[0];
                end
                {alu_overflow, alu_zero, alu_carry, alu_result} <= r;
            end
        end
    end

    // ALU for dut1: carry flag stuck at 1
    always @(posedge clk) begin
        logic [6:0] r;
        if (rst) begin
            alu_st1 <= 2'd0;
            {alu_overflow1, alu_zero1, alu_carry1, alu_result1} <= 7'd0;
        end else begin
            alu_st1 <= (alu_st1 == 2'd2) ? 2'd0 : alu_st1 + 2'd1;
            if (alu_st1 == 2'd2) begin
                r = alu_model(alu_a1, alu_b1, alu_op1);
                r[4] = 1'b1;
                {alu_overflow1, alu_zero1, alu_carry1, alu_result1} <= r;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 16'(done), 16'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_done"}, 16'(done), 16'd0);
        chk({tag, "_ops"}, {6'd0, alu_op, alu_b, alu_a}, 16'd0);
        chk({tag, "_op_count"}, op_count, 16'd0);
        chk({tag, "_mismatch"}, mismatch_cnt, 16'd0);
        chk({tag, "_first_err"}, first_err_idx, 16'hFFFF);
        chk({tag, "_sig"}, signature, 16'd0);
    endtask

    task automatic chk_final(input string tag, input logic [15:0] mm, input logic [15:0] fe, input logic [15:0] sig);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_op_count"}, op_count, 16'd4);
        chk({tag, "_mismatch"}, mismatch_cnt, mm);
        chk({tag, "_first_err"}, first_err_idx, fe);
        chk({tag, "_sig"}, signature, sig);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        start1     = 1'b0;
        fault_mode = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_state("reset");
        chk("reset_dut1_sig", signature1, 16'd0);
        rst = 1'b0;

        // Cycle 0 after release is phase 0; start in cycle 1 is armed on the phase-1 edge,
        // so op 0 is issued on the very next (phase-2) edge
        @(negedge clk);
        pulse_start();
        chk("pre_issue_a", {12'd0, alu_a}, 16'd0);
        @(negedge clk);
        chk("first_issue", {6'd0, alu_op, alu_b, alu_a}, {6'd0, 2'b00, 4'hE, 4'h1});
        chk("busy_running", 16'(busy), 16'd1);
        cyc = 2;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_latency_ok", 16'(cyc <= 18), 16'd1);
        chk_final("clean", 16'd0, 16'hFFFF, SIG_CLEAN);
        repeat (3) @(negedge clk);
        chk("done_held", 16'(done), 16'd1);
        chk("idle_busy", 16'(busy), 16'd0);

        // Trojan on op 2
        fault_mode = 1'b1;
        pulse_start();
        chk("done_cleared", 16'(done), 16'd0);
        wait_done("fault");
        chk_final("fault", 16'd1, 16'd2, SIG_FAULT);
        fault_mode = 1'b0;

        // Start pulses while busy are ignored
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        wait_done("restart");
        chk_final("restart", 16'd0, 16'hFFFF, SIG_CLEAN);

        // Reset in the middle of a run, then a fresh run
        pulse_start();
        repeat (10) @(negedge clk);
        chk("midrun_progress", 16'(op_count != 16'd0), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrun_rst");
        pulse_start();
        wait_done("after_rst");
        chk_final("after_rst", 16'd0, 16'hFFFF, SIG_CLEAN);

        // Stuck carry, single op: golden carry of 1+E is 0 -> one mismatch
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("carry1_done", 16'(done1), 16'd1);
        chk("carry1_op_count", op_count1, 16'd1);
        chk("carry1_mismatch", mismatch_cnt1, 16'd1);
        chk("carry1_first_err", first_err_idx1, 16'd0);
        chk("carry1_sig", signature1, SIG_CARRY1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
